// File: rtl/rv_mem_arbiter_pkg.sv
// Shared types and defaults for the IF/LSU memory-port arbiter.
package rv_mem_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_IF  = 2'd1,
    ARB_BUSY_LSU = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rv_arb_select.sv
// Priority select between fetch and LSU: LSU wins unless fetch has been starved MAX_WAIT times.
module rv_arb_select
  import rv_mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic             arb_en,
  input  logic             if_req,
  input  logic             lsu_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             sel_if,
  output logic             sel_lsu
);

  logic if_forced;

  always_comb begin
    if_forced = if_req && (starve_cnt >= CNT_W'(MAX_WAIT));
    sel_lsu   = arb_en && lsu_req && !if_forced;
    sel_if    = arb_en && if_req && !sel_lsu;
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and the LSU.
//
// state        | meaning
// ARB_IDLE     | no transaction in flight; arbitrate and present request to memory
// ARB_BUSY_IF  | fetch granted, waiting for mem_rvalid
// ARB_BUSY_LSU | load/store granted, waiting for mem_rvalid
module rv_mem_arbiter
  import rv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    lsu_req,
  input  logic                    lsu_we,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_be,
  output logic                    lsu_gnt,
  output logic                    lsu_rvalid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    err_spur
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             arb_en, sel_if, sel_lsu;

  // Selection is only live in IDLE and never while reset is held.
  assign arb_en = (state == ARB_IDLE) && !rst;

  rv_arb_select #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_select (
    .arb_en     (arb_en),
    .if_req     (if_req),
    .lsu_req    (lsu_req),
    .starve_cnt (starve_cnt),
    .sel_if     (sel_if),
    .sel_lsu    (sel_lsu)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = sel_if | sel_lsu;
    if_gnt     = sel_if & mem_gnt;
    lsu_gnt    = sel_lsu & mem_gnt;
    if_rvalid  = 1'b0;
    lsu_rvalid = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (if_gnt)       state_nxt = ARB_BUSY_IF;
        else if (lsu_gnt) state_nxt = ARB_BUSY_LSU;
      end
      ARB_BUSY_IF: begin
        if (mem_rvalid) begin
          if_rvalid = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      ARB_BUSY_LSU: begin
        if (mem_rvalid) begin
          lsu_rvalid = 1'b1;
          state_nxt  = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Only lost arbitrations that actually reached memory count toward starvation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (if_gnt)
      starve_cnt <= '0;
    else if (lsu_gnt && if_req && (starve_cnt < CNT_W'(MAX_WAIT)))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_spur <= 1'b0;
    else if ((state == ARB_IDLE) && mem_rvalid)
      err_spur <= 1'b1;
  end

  assign mem_we    = sel_lsu & lsu_we;
  assign mem_addr  = sel_lsu ? lsu_addr : if_addr;
  assign mem_wdata = sel_lsu ? lsu_wdata : '0;
  assign mem_be    = sel_lsu ? lsu_be : '1;
  assign if_rdata  = mem_rdata;
  assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: vector table, directed corner sequences, random vs. model.
module tb_rv_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [BW-1:0] lsu_be;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;
  logic          err_spur;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_be(lsu_be),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_spur(err_spur)
  );

  typedef struct {
    logic          if_req, lsu_req, lsu_we;
    logic [BW-1:0] lsu_be;
    logic          mem_gnt;
    logic          e_req, e_ifg, e_lsug, e_we;
    logic [BW-1:0] e_be;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_idle();
    if_req = 0; if_addr = '0;
    lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic next_drive();
    @(posedge clk); #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_drive(); rst = 1; drive_idle();
    next_drive(); next_drive(); rst = 0;
  endtask

  // Both requesters held, memory always accepts and answers one cycle later.
  task automatic starve_rounds(input string tag, input int n, input int if_win_at);
    for (int k = 0; k < n; k++) begin
      mem_gnt = 1; mem_rvalid = 0;
      to_sample();
      chk($sformatf("%s_arb%0d", tag, k), {if_gnt, lsu_gnt}, (k == if_win_at) ? 2'b10 : 2'b01);
      next_drive(); mem_rvalid = 1;
      to_sample();
      next_drive();
    end
    mem_rvalid = 0;
  endtask

  // Random-traffic reference state
  bit      m_busy, m_owner_if;
  int      m_starve, resp_wait;
  bit      if_got, lsu_got;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; drive_idle();

    // reset holds everything quiet even with both requesters asserted
    next_drive(); rst = 1; if_req = 1; lsu_req = 1; mem_gnt = 1; if_addr = 32'h40;
    to_sample();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_gnts", {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, err_spur}, 0);
    next_drive(); rst = 0; lsu_req = 0;
    to_sample();
    chk("rst_if_first", {if_gnt, mem_req, mem_addr}, {2'b11, 32'h40});
    next_drive(); if_req = 0; mem_gnt = 0; mem_rvalid = 1;
    to_sample();
    chk("rst_if_rvalid", if_rvalid, 1);
    next_drive(); mem_rvalid = 0;

    // single-cycle arbitration table, fresh reset per row
    vt[0] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'hA0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'hA0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 32'hA0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 32'hB0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 32'hB0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 32'hB0};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      if_req = vt[i].if_req; lsu_req = vt[i].lsu_req; lsu_we = vt[i].lsu_we;
      lsu_be = vt[i].lsu_be; mem_gnt = vt[i].mem_gnt;
      if_addr = 32'hA0; lsu_addr = 32'hB0; lsu_wdata = 32'h1234;
      to_sample();
      chk($sformatf("vec%0d", i), {mem_req, if_gnt, lsu_gnt, mem_we, mem_be, mem_addr},
          {vt[i].e_req, vt[i].e_ifg, vt[i].e_lsug, vt[i].e_we, vt[i].e_be, vt[i].e_addr});
    end

    // fetch with response two cycles after grant
    do_reset();
    if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    to_sample();
    chk("fetch_gnt", {if_gnt, mem_we, mem_be, mem_addr}, {2'b10, 4'hF, 32'h100});
    next_drive(); if_req = 0; mem_gnt = 0;
    to_sample();
    chk("fetch_wait", {mem_req, if_rvalid}, 0);
    next_drive(); mem_rvalid = 1; mem_rdata = 32'h00500093;
    to_sample();
    chk("fetch_rvalid", {if_rvalid, lsu_rvalid, if_rdata}, {2'b10, 32'h00500093});
    next_drive(); mem_rvalid = 0;

    // LSU store wins a conflict, fetch follows
    do_reset();
    if_req = 1; if_addr = 32'h300;
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h2000; lsu_wdata = 32'hDEADBEEF; lsu_be = 4'h3;
    mem_gnt = 1;
    to_sample();
    chk("conf_lsu", {lsu_gnt, if_gnt, mem_we, mem_be, mem_addr, mem_wdata},
        {3'b101, 4'h3, 32'h2000, 32'hDEADBEEF});
    next_drive(); lsu_req = 0; mem_rvalid = 1;
    to_sample();
    chk("conf_lsu_rv", {lsu_rvalid, if_rvalid, mem_req}, 3'b100);
    next_drive(); mem_rvalid = 0;
    to_sample();
    chk("conf_if", {if_gnt, mem_we, mem_be, mem_addr, mem_wdata}, {2'b10, 4'hF, 32'h300, 32'h0});
    next_drive(); if_req = 0; mem_gnt = 0; mem_rvalid = 1;
    to_sample();
    chk("conf_if_rv", {if_rvalid, lsu_rvalid}, 2'b10);
    next_drive(); mem_rvalid = 0;

    // starvation: four losses, fifth arbitration forced to fetch, then counter cleared
    do_reset();
    if_req = 1; if_addr = 32'h500; lsu_req = 1; lsu_addr = 32'h600;
    starve_rounds("starve", 6, 4);

    // memory stalls must not count as lost arbitrations
    do_reset();
    if_req = 1; if_addr = 32'h500; lsu_req = 1; lsu_addr = 32'h440; mem_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      to_sample();
      chk($sformatf("stall%0d", k), {mem_req, if_gnt, lsu_gnt, mem_addr}, {3'b100, 32'h440});
      next_drive();
    end
    starve_rounds("stall", 5, 4);

    // spurious response in IDLE
    do_reset();
    mem_rvalid = 1;
    to_sample();
    chk("spur_fwd", {if_rvalid, lsu_rvalid}, 0);
    next_drive(); mem_rvalid = 0;
    to_sample();
    chk("spur_sticky", err_spur, 1);
    do_reset();
    to_sample();
    chk("spur_rst_clr", err_spur, 0);
    // reset while a load is outstanding, then its late response
    next_drive(); lsu_req = 1; lsu_addr = 32'h80; mem_gnt = 1;
    to_sample();
    chk("late_gnt", lsu_gnt, 1);
    next_drive(); lsu_req = 0; mem_gnt = 0; rst = 1;
    to_sample();
    chk("late_in_rst", {mem_req, lsu_rvalid, err_spur}, 0);
    next_drive(); rst = 0; mem_rvalid = 1;
    to_sample();
    chk("late_fwd", {lsu_rvalid, if_rvalid}, 0);
    next_drive(); mem_rvalid = 0;
    to_sample();
    chk("late_spur", err_spur, 1);

    // random traffic against a transaction-level model
    do_reset();
    m_busy = 0; m_owner_if = 0; m_starve = 0; resp_wait = 0; if_got = 0; lsu_got = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      logic pick_if, pick_lsu, m_req, m_ifg, m_lsug, m_ifrv, m_lsurv, m_we;
      logic [AW-1:0] m_addr;
      if (cyc != 0) next_drive();
      if (if_got) if_req = 0;
      if (lsu_got) lsu_req = 0;
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsu_req && $urandom_range(0, 2) != 0) begin
        lsu_req = 1; lsu_we = 1'($urandom); lsu_addr = $urandom;
        lsu_wdata = $urandom; lsu_be = 4'($urandom);
      end
      mem_gnt = ($urandom_range(0, 3) != 0);
      mem_rvalid = 0;
      if (resp_wait > 0) begin
        resp_wait--;
        if (resp_wait == 0) mem_rvalid = 1;
      end
      mem_rdata = $urandom;
      to_sample();

      pick_if = 0; pick_lsu = 0; m_ifrv = 0; m_lsurv = 0;
      if (!m_busy) begin
        pick_lsu = lsu_req && !(if_req && m_starve >= MW);
        pick_if  = !pick_lsu && if_req;
      end else begin
        m_ifrv  = m_owner_if && mem_rvalid;
        m_lsurv = !m_owner_if && mem_rvalid;
      end
      m_req  = pick_if || pick_lsu;
      m_ifg  = pick_if && mem_gnt;
      m_lsug = pick_lsu && mem_gnt;
      m_we   = pick_lsu && lsu_we;
      m_addr = pick_lsu ? lsu_addr : (pick_if ? if_addr : '0);
      chk($sformatf("rand%0d", cyc),
          {mem_req, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, err_spur, mem_req ? {mem_we, mem_addr} : 33'h0},
          {m_req, m_ifg, m_lsug, m_ifrv, m_lsurv, 1'b0, m_req ? {m_we, m_addr} : 33'h0});

      if (m_busy) begin
        if (mem_rvalid) m_busy = 0;
      end else if (m_ifg) begin
        m_busy = 1; m_owner_if = 1; m_starve = 0;
      end else if (m_lsug) begin
        m_busy = 1; m_owner_if = 0;
        if (if_req && m_starve < MW) m_starve++;
      end
      if (m_ifg || m_lsug) resp_wait = $urandom_range(1, 3);
      if_got  = m_ifg;
      lsu_got = m_lsug;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
